// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream handshake bundle between NUM_REQ requesters, the arbiter and the UART TX byte port.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_start;
  logic                          tx_busy;

  modport master (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_start
  );

  modport slave (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data, tx_start
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART TX byte port among NUM_REQ requesters.
// Define UART_ARB_HDR_EN to prefix every grant with a header byte carrying the grant id.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  uart_tx_arbiter_if.master          bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active,
  output logic                       timeout_err
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BURST_CAP = BW'(MAX_BURST);
  localparam logic [SW-1:0] STALL_CAP = SW'(TIMEOUT);
  localparam logic [SW-1:0] STALL_LIM = SW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
`ifdef UART_ARB_HDR_EN
    HDR,
`endif
    SEND,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t                state, state_nxt;
  logic [GW-1:0]         ptr, ptr_nxt, grant_nxt, pick;
  logic                  pick_ok;
  logic                  active_nxt, timeout_nxt, start_nxt;
  logic                  last, last_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic [BW-1:0]         byte_cnt, byte_nxt;
  logic [SW-1:0]         stall_cnt, stall_nxt;

  // Scan starts just after the last served requester, so it becomes lowest priority.
  always_comb begin
    pick_ok = 1'b0;
    pick    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!pick_ok && bus.req_valid[(int'(ptr) + i) % NUM_REQ]) begin
        pick_ok = 1'b1;
        pick    = GW'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that skipped one would infer a latch.
    state_nxt     = state;
    ptr_nxt       = ptr;
    grant_nxt     = grant_id;
    active_nxt    = active;
    timeout_nxt   = 1'b0;
    start_nxt     = 1'b0;
    data_nxt      = bus.tx_data;
    last_nxt      = last;
    byte_nxt      = byte_cnt;
    stall_nxt     = stall_cnt;
    bus.req_ready = '0;

    unique case (state)
      IDLE: begin
        if (|bus.req_valid) state_nxt = ARB;
      end

      ARB: begin
        if (pick_ok) begin
          grant_nxt  = pick;
          active_nxt = 1'b1;
          byte_nxt   = '0;
          stall_nxt  = '0;
          last_nxt   = 1'b0;
`ifdef UART_ARB_HDR_EN
          state_nxt  = HDR;
`else
          state_nxt  = SEND;
`endif
        end else begin
          state_nxt = IDLE;
        end
      end

`ifdef UART_ARB_HDR_EN
      HDR: begin
        if (!bus.tx_busy) begin
          start_nxt = 1'b1;
          data_nxt  = DATA_WIDTH'(grant_id);
          state_nxt = WAIT_ACK;
        end
      end
`endif

      SEND: begin
        if (bus.req_valid[grant_id]) begin
          if (!bus.tx_busy) begin
            bus.req_ready[grant_id] = 1'b1;
            start_nxt = 1'b1;
            data_nxt  = bus.req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
            last_nxt  = bus.req_last[grant_id];
            byte_nxt  = (byte_cnt == BURST_CAP) ? byte_cnt : byte_cnt + 1'b1;
            state_nxt = WAIT_ACK;
          end
        end else if (stall_cnt == STALL_LIM) begin
          timeout_nxt = 1'b1;
          ptr_nxt     = grant_id;
          active_nxt  = 1'b0;
          state_nxt   = IDLE;
        end else if (stall_cnt != STALL_CAP) begin
          stall_nxt = stall_cnt + 1'b1;
        end
      end

      WAIT_ACK: begin
        if (bus.tx_busy) state_nxt = WAIT_DONE;
      end

      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          // A header leaves last=0 and byte_cnt=0, so it always falls through to SEND.
          if (last || byte_cnt == BURST_CAP) begin
            ptr_nxt    = grant_id;
            active_nxt = 1'b0;
            state_nxt  = IDLE;
          end else begin
            stall_nxt = '0;
            state_nxt = SEND;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= GW'(NUM_REQ - 1);
      grant_id     <= '0;
      active       <= 1'b0;
      timeout_err  <= 1'b0;
      bus.tx_start <= 1'b0;
      bus.tx_data  <= '0;
      last         <= 1'b0;
      byte_cnt     <= '0;
      stall_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      grant_id     <= grant_nxt;
      active       <= active_nxt;
      timeout_err  <= timeout_nxt;
      bus.tx_start <= start_nxt;
      bus.tx_data  <= data_nxt;
      last         <= last_nxt;
      byte_cnt     <= byte_nxt;
      stall_cnt    <= stall_nxt;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues, a UART TX busy model and a packet-level
// round-robin reference model producing the expected (grant, byte) stream; follows UART_ARB_HDR_EN.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;
  localparam int TIMEOUT    = 16;
  localparam int GW         = $clog2(NUM_REQ);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [GW-1:0] grant_id;
  logic active, timeout_err;

  logic [NUM_REQ-1:0]            rv = '0;
  logic [NUM_REQ*DATA_WIDTH-1:0] rd = '0;
  logic [NUM_REQ-1:0]            rl = '0;
  logic                          tx_busy_m = 1'b0;
  int                            busy_cnt = 0;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();
  assign bus.req_valid = rv;
  assign bus.req_data  = rd;
  assign bus.req_last  = rl;
  assign bus.tx_busy   = tx_busy_m;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .grant_id(grant_id), .active(active), .timeout_err(timeout_err)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // UART TX: busy rises the cycle after tx_start and stays high 10 cycles; ignores rst_n.
  always @(posedge clk) begin
    if (bus.tx_start) begin
      tx_busy_m <= 1'b1;
      busy_cnt  <= 9;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      tx_busy_m <= 1'b0;
    end
  end

  logic [8:0]  tq [NUM_REQ][$];
  logic [8:0]  mq [NUM_REQ][$];
  logic [15:0] obs[$];
  logic [15:0] expq[$];
  int          m_ptr = NUM_REQ - 1;
  int          ready_cnt [NUM_REQ];
  logic [NUM_REQ-1:0] ready_seen = '0;
  int first_start_cyc = -1, last_start_cyc = 0;
  int to_cnt = 0, to_gap = 0, to_active_bad = 0, ready_viol = 0;
  int n_checks = 0, n_pass = 0;

  // Requesters: valid whenever their queue holds a byte; pop on the edge where req_ready was high.
  initial begin
    for (int i = 0; i < NUM_REQ; i++) ready_cnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ready_seen[i] && tq[i].size() > 0) begin
          tq[i].delete(0);
          ready_cnt[i]++;
        end
        if (tq[i].size() > 0) begin
          rv[i] = 1'b1;
          rd[i*DATA_WIDTH +: DATA_WIDTH] = tq[i][0][7:0];
          rl[i] = tq[i][0][8];
        end else begin
          rv[i] = 1'b0;
          rd[i*DATA_WIDTH +: DATA_WIDTH] = '0;
          rl[i] = 1'b0;
        end
      end
      #1 ready_seen = bus.req_ready;
    end
  end

  initial forever begin
    logic [NUM_REQ-1:0] gmask;
    @(negedge clk);
    #2;
    if (bus.tx_start) begin
      obs.push_back({8'(grant_id), bus.tx_data});
      last_start_cyc = cyc;
      if (first_start_cyc < 0) first_start_cyc = cyc;
    end
    if (timeout_err) begin
      to_cnt++;
      to_gap = cyc - last_start_cyc;
      if (active) to_active_bad++;
    end
    gmask = NUM_REQ'(1) << grant_id;
    if (rst_n && ((!active && bus.req_ready != '0) || (bus.req_ready & ~gmask) != '0))
      ready_viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push_tx(input int r, input logic [7:0] d, input logic l);
    tq[r].push_back({l, d});
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input logic l);
    tq[r].push_back({l, d});
    mq[r].push_back({l, d});
  endtask

  task automatic exp_grant(input int r);
`ifdef UART_ARB_HDR_EN
    expq.push_back({8'(r), 8'(r)});
`else
    if (r < 0) expq.push_back('0);
`endif
  endtask

  // Reference: serve pending packets round-robin, at most MAX_BURST bytes per grant.
  task automatic model_run();
    bit any;
    int r, n;
    logic [8:0] b;
    do begin
      any = 0;
      r   = 0;
      for (int k = 1; k <= NUM_REQ; k++)
        if (!any && mq[(m_ptr + k) % NUM_REQ].size() > 0) begin
          any = 1;
          r   = (m_ptr + k) % NUM_REQ;
        end
      if (any) begin
        exp_grant(r);
        n = 0;
        do begin
          b = mq[r].pop_front();
          expq.push_back({8'(r), b[7:0]});
          n++;
        end while (!b[8] && n < MAX_BURST && mq[r].size() > 0);
        m_ptr = r;
      end
    end while (any);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NUM_REQ; i++) if (tq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string tag);
    int  n = 0;
    bit  done = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      #3;
      done = !active && all_empty() && !tx_busy_m && !bus.tx_start;
      n++;
    end
    check({tag, "_idle"}, 32'(done), 32'd1);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_count"}, obs.size(), expq.size());
    for (int i = 0; i < obs.size() && i < expq.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(obs[i]), 32'(expq[i]));
    obs.delete();
    expq.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_active"},  32'(active), 0);
    check({tag, "_grant"},   32'(grant_id), 0);
    check({tag, "_start"},   32'(bus.tx_start), 0);
    check({tag, "_data"},    32'(bus.tx_data), 0);
    check({tag, "_timeout"}, 32'(timeout_err), 0);
    check({tag, "_ready"},   32'(bus.req_ready), 0);
  endtask

  initial begin
    int t0, r0, n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // All four requesters with one-byte packets, then requesters 0 and 2 again.
    @(posedge clk); #1;
    for (int r = 0; r < NUM_REQ; r++) push_byte(r, 8'(8'hB0 + r), 1'b1);
    model_run();
    wait_idle("rr1");
    push_byte(0, 8'hC0, 1'b1);
    push_byte(2, 8'hC2, 1'b1);
    model_run();
    wait_idle("rr2");
    compare_stream("rr");

    // Two-byte packet from requester 1, with start latency.
    @(posedge clk); #1;
    r0 = ready_cnt[1];
    first_start_cyc = -1;
    push_byte(1, 8'hA5, 1'b0);
    push_byte(1, 8'h5A, 1'b1);
    @(negedge clk); #2;
    t0 = cyc;
    model_run();
    wait_idle("two");
    check("start_latency", first_start_cyc - t0, 3);
    check("two_ready1", ready_cnt[1] - r0, 2);
    check("two_grant", 32'(grant_id), 1);
    check("two_active", 32'(active), 0);
    compare_stream("two");

    // Six-byte packet crossing the burst cap while requester 3 waits.
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) push_byte(2, 8'(8'h20 + i), i == 5);
    for (int i = 0; i < 2; i++) push_byte(3, 8'(8'h30 + i), i == 1);
    model_run();
    wait_idle("burst");
    compare_stream("burst");

    // Requester 0 stalls mid-packet: timeout after TIMEOUT idle SEND cycles, then requester 1.
    @(posedge clk); #1;
    to_cnt = 0;
    push_tx(0, 8'h31, 1'b0);
    push_tx(1, 8'h77, 1'b1);
    exp_grant(0); expq.push_back({8'd0, 8'h31});
    exp_grant(1); expq.push_back({8'd1, 8'h77});
    wait_idle("stall");
    check("timeout_pulses", to_cnt, 1);
    check("timeout_gap", to_gap, 28);
    check("timeout_active", to_active_bad, 0);
    @(posedge clk); #1;
    push_tx(0, 8'h32, 1'b1);
    exp_grant(0); expq.push_back({8'd0, 8'h32});
    wait_idle("resume");
    compare_stream("timeout");
    m_ptr = 0;

    // Single byte from requester 3 (header precedes it when enabled).
    @(posedge clk); #1;
    r0 = ready_cnt[3];
    push_byte(3, 8'h11, 1'b1);
    model_run();
    wait_idle("single");
    check("single_ready3", ready_cnt[3] - r0, 1);
    compare_stream("single");

    for (int round = 0; round < 6; round++) begin
      @(posedge clk); #1;
      for (int r = 0; r < NUM_REQ; r++) begin
        int npk = $urandom_range(0, 2);
        for (int p = 0; p < npk; p++) begin
          int len = $urandom_range(1, 7);
          for (int i = 0; i < len; i++) push_byte(r, 8'($urandom), i == len - 1);
        end
      end
      model_run();
      wait_idle($sformatf("rand%0d", round));
      compare_stream($sformatf("rand%0d", round));
    end

    // Reset while a byte is in flight; pending requester 0 must win the next grant.
    @(posedge clk); #1;
    push_tx(2, 8'hE1, 1'b0);
    push_tx(2, 8'hE2, 1'b0);
    push_tx(2, 8'hE3, 1'b1);
    n = 0;
    while (tq[2].size() != 2 && n < 200) begin
      @(negedge clk); #3;
      n++;
    end
    check("rst_setup", tq[2].size(), 2);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    push_tx(0, 8'h0F, 1'b1);
    @(negedge clk); #2;
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    obs.delete();
    expq.delete();
    exp_grant(0); expq.push_back({8'd0, 8'h0F});
    exp_grant(2); expq.push_back({8'd2, 8'hE2}); expq.push_back({8'd2, 8'hE3});
    wait_idle("post_rst");
    compare_stream("post_rst");

    check("ready_invariant", ready_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
